// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter that shares one Wishbone master command port among NUM_REQ requesters.
// Grant one cycle after a request is seen in IDLE; a requester stays granted until its done/timeout pulse.
module wb_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [32*NUM_REQ-1:0]  req_addr_i,
    input  logic [4*NUM_REQ-1:0]   req_sel_i,
    input  logic [NUM_REQ-1:0]     req_we_i,
    input  logic [32*NUM_REQ-1:0]  req_dat_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [NUM_REQ-1:0]     timeout_o,
    output logic [31:0]            rd_dat_o,
    output logic                   busy_o,
    output logic                   start,
    output logic [31:0]            address,
    output logic [3:0]             selection,
    output logic                   write,
    output logic [31:0]            data_wr,
    input  logic                   active,
    input  logic [31:0]            data_rd
);
    localparam int          IW      = $clog2(NUM_REQ);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACT, S_WAIT_DONE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d, to_q, to_d;
    logic [31:0]          rd_dat_q, rd_dat_d, addr_q, addr_d, wdat_q, wdat_d;
    logic [3:0]           sel_q, sel_d;
    logic                 write_q, write_d, start_q, start_d, busy_q, busy_d;
    logic [15:0]          wd_q, wd_d;
    logic [IW-1:0]        last_q, last_d, cur_q, cur_d;
    logic                 win_vld;
    logic [IW-1:0]        win_idx, cand;

    // First requesting index strictly after last_q, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_q) + i) % NUM_REQ);
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        to_d     = '0;
        rd_dat_d = rd_dat_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        write_d  = write_q;
        wdat_d   = wdat_q;
        start_d  = 1'b0;
        wd_d     = wd_q;
        last_d   = last_q;
        cur_d    = cur_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld && !active) begin
                    cur_d          = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    addr_d         = req_addr_i[32*win_idx +: 32];
                    sel_d          = req_sel_i[4*win_idx +: 4];
                    write_d        = req_we_i[win_idx];
                    wdat_d         = req_dat_i[32*win_idx +: 32];
                    start_d        = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT_ACT;
            end
            S_WAIT_ACT, S_WAIT_DONE: begin
                wd_d = wd_q + 16'd1;
                if (state_q == S_WAIT_DONE && !active) begin
                    if (!write_q) begin
                        rd_dat_d = data_rd;
                    end
                    done_d[cur_q] = 1'b1;
                    state_d       = S_DONE;
                end else if (wd_q == TO_LAST) begin
                    done_d[cur_q] = 1'b1;
                    to_d[cur_q]   = 1'b1;
                    state_d       = S_DONE;
                end else if (state_q == S_WAIT_ACT && active) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                last_d  = cur_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            to_q     <= '0;
            rd_dat_q <= '0;
            addr_q   <= '0;
            sel_q    <= '0;
            write_q  <= 1'b0;
            wdat_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            wd_q     <= '0;
            last_q   <= IW'(NUM_REQ - 1);
            cur_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            to_q     <= to_d;
            rd_dat_q <= rd_dat_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            write_q  <= write_d;
            wdat_q   <= wdat_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            wd_q     <= wd_d;
            last_q   <= last_d;
            cur_q    <= cur_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign timeout_o = to_q;
    assign rd_dat_o  = rd_dat_q;
    assign busy_o    = busy_q;
    assign start     = start_q;
    assign address   = addr_q;
    assign selection = sel_q;
    assign write     = write_q;
    assign data_wr   = wdat_q;
endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Round-robin arbiter and sequencer that shares a single `wb_master_interface` command port among `NUM_REQ` internal requesters (DAQ, DSP engines, configuration logic). It accepts one single-beat request at a time and latches that request's command. It pulses `start` to the master interface, tracks `active` until the Wishbone cycle completes, and returns read data plus a completion or timeout pulse to the granted requester. A watchdog guards against a slave that never acknowledges.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 255: maximum cycles from `start` to transaction end before abort (1..65535).

Ports:
- `wb_clk`  in  1  clock; all logic on the rising edge.
- `wb_rst`  in  1  synchronous, active-high reset.
- `req_i`  in  NUM_REQ  per-requester request level.
- `req_addr_i`  in  32*NUM_REQ  byte address; requester n occupies bits [32n+31:32n].
- `req_sel_i`  in  4*NUM_REQ  byte selects.
- `req_we_i`  in  NUM_REQ  1 = write, 0 = read.
- `req_dat_i`  in  32*NUM_REQ  write data.
- `gnt_o`  out  NUM_REQ  one-hot grant; held for the whole transaction.
- `done_o`  out  NUM_REQ  one-cycle completion pulse.
- `timeout_o`  out  NUM_REQ  one-cycle abort pulse; coincides with `done_o`.
- `rd_dat_o`  out  32  read data of the last completed read; holds its value until the next read completes.
- `busy_o`  out  1  arbiter is not in IDLE.
- `start`  out  1  one-cycle command strobe to the master interface.
- `address`  out  32  latched command address.
- `selection`  out  4  latched byte selects.
- `write`  out  1  latched direction.
- `data_wr`  out  32  latched write data.
- `active`  in  1  master interface transaction in progress.
- `data_rd`  in  32  master interface read data, valid when `active` falls.

## Operation
- FSM states: IDLE, ISSUE, WAIT_ACT, WAIT_DONE, DONE.
- **IDLE**
  - Arbitrate only when some `req_i` is high and `active` = 0.
  - Winner: first requester with `req_i` high, searching upward (with wrap) from `last + 1`.
  - Latch the winner's address, sel, we and data into the command registers.
  - Set `gnt_o[winner]` and go to ISSUE.
- **ISSUE**: `start` = 1 for exactly one cycle; clear the watchdog; go to WAIT_ACT.
- **WAIT_ACT**: wait for `active` = 1, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `active` = 0.
  - On that cycle, capture `data_rd` into `rd_dat_o` if the command was a read.
  - Go to DONE.
- **DONE**
  - Pulse `done_o[g]`, clear `gnt_o`, update `last` = g.
  - Return to IDLE.
- **Watchdog**
  - 16-bit counter increments in WAIT_ACT and WAIT_DONE.
  - At count == TIMEOUT: go to DONE with `timeout_o[g]` also pulsed; `rd_dat_o` is not updated.
- **Stale `active` after timeout**: if `active` is still 1 after a timeout, IDLE does not arbitrate until `active` = 0.
- **Request signalling**
  - `req_i` and fields may change after the grant; the latched command is used.
  - Dropping `req_i` mid-transaction does not abort it; `done_o` is still pulsed.
  - A requester that wants another transfer keeps `req_i` high after `done_o`. It is re-eligible the next IDLE cycle, behind the others in rotation.
- **Reset values**
  - `gnt_o`, `done_o`, `timeout_o`, `start`, `busy_o`, `write` = 0.
  - `address`, `selection`, `data_wr`, `rd_dat_o` = 0.
  - `last` = NUM_REQ-1, so requester 0 has top priority first.
  - State = IDLE.

## Timing
- Request seen in IDLE at edge T: `gnt_o` and `busy_o` valid after T; `start` high during cycle T+1.
- Minimum turnaround from request to `done_o` is 4 cycles plus the master's `active` duration.
- `done_o` asserts the cycle after `active` is sampled low in WAIT_DONE.
- Back-to-back grants are separated by at least one IDLE cycle after DONE.
- Simultaneous requests are resolved in one cycle; no starvation. Worst-case wait is NUM_REQ-1 transactions.
- Reset asserted mid-transaction:
  - All outputs reach reset values on the next edge.
  - No `done_o` is issued for the killed transaction.
  - Arbitration restarts at requester 0.

## Test plan
- **Single write**
  - Stimulus: req0 write 0x20000000, sel 0xF, data 0xA5A5B6B6.
  - Required: one `start` pulse, then one `done_o[0]` pulse; ram0 word 0 reads 0xA5A5B6B6.
- **Readback**
  - Stimulus: req1 reads 0x20000000.
  - Required: `rd_dat_o` = 0xA5A5B6B6 in the `done_o[1]` cycle; `timeout_o` stays 0.
- **Round-robin**
  - Stimulus: req0..req3 assert together (NUM_REQ = 4), each writing a distinct value to RAM0..RAM3, then re-request.
  - Required: grant order 0,1,2,3 then 0,1,2,3; never two `gnt_o` bits high at once.
- **Timeout**
  - Stimulus: TIMEOUT = 16; stub holds `active` high.
  - Required: `done_o[g]` and `timeout_o[g]` pulse exactly 16 cycles after WAIT_ACT entry; no new grant while `active` stays 1.
- **Reset mid-transaction**
  - Stimulus: assert `wb_rst` during WAIT_DONE.
  - Required: outputs zero next cycle and no `done_o`; after release, a pending req2 and req0 are served req0 first.
- **Request dropped after grant**
  - Stimulus: req3 deasserts one cycle after grant.
  - Required: the transaction completes with `done_o[3]`; req3 is not re-granted.
